// File: rtl/axi_rd_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_pkg
// Shared definitions for the AXI-Lite read-burst engine:
//   - FSM state encoding (IDLE / ADDR / DATA / FIN)
//   - AXI read response codes
//   - byte_shift(): converts a word index into a byte address shift for a
//     given data width (2 for 32-bit words, 3 for 64-bit words)
// No ports; imported by axi_read_burst and axi_rd_outreg.
// -----------------------------------------------------------------------------
package axi_rd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int byte_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_rd_outreg.sv
// -----------------------------------------------------------------------------
// axi_rd_outreg
// One-entry valid/ready holding register for the read-data stream.
// The entry can be refilled in the same cycle it is drained, so a burst with
// out_ready held high streams one word per accepted beat.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data, in_valid     word offered by the burst engine
//   in_ready              register can take a word this cycle
//   out_data, out_valid   held word towards the consumer
//   out_ready             consumer accepts the held word
// -----------------------------------------------------------------------------
module axi_rd_outreg
  import axi_rd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  // Free when empty, or when the held word leaves this very cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_read_burst.sv
// -----------------------------------------------------------------------------
// axi_read_burst
// Reads `count` consecutive words starting at word index `base_idx` over an
// AXI-Lite read channel, one transaction at a time, and streams the returned
// words out through a one-entry valid/ready register.
//
// Build option:
//   AXI_RD_ERR_ABORT_EN  when defined, a beat with a non-OKAY response is
//                        dropped and the rest of the burst is skipped; when
//                        undefined, error beats are forwarded and the burst
//                        runs to completion. err is sticky in both builds.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, base_idx, count        burst request (sampled only while idle)
//   busy, done, err               status: busy level, done pulse, sticky error
//   out_data, out_valid, out_ready  read-data stream
//   arg_0_s_axil_ar*              AXI-Lite read address channel (master side)
//   arg_0_s_axil_r*               AXI-Lite read data channel (master side)
// -----------------------------------------------------------------------------
module axi_read_burst
  import axi_rd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_idx,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] arg_0_s_axil_araddr,
  output logic [2:0]        arg_0_s_axil_arprot,
  output logic              arg_0_s_axil_arvalid,
  input  logic              arg_0_s_axil_arready,
  input  logic [DATA_W-1:0] arg_0_s_axil_rdata,
  input  logic [1:0]        arg_0_s_axil_rresp,
  input  logic              arg_0_s_axil_rvalid,
  output logic              arg_0_s_axil_rready
);

  localparam int SHIFT = byte_shift(DATA_W);

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  i_r;
  logic [CNT_W-1:0]  i_next;
  logic [ADDR_W-1:0] word_idx;
  logic              reg_in_ready;
  logic              reg_in_valid;
  logic              beat_fire;
  logic              beat_err;

  assign busy     = (state != ST_IDLE);
  assign i_next   = i_r + 1'b1;

  // Word index wraps modulo 2^ADDR_W before being scaled to a byte address;
  // the shift then drops the top bits, giving the required address wrap.
  assign word_idx = base_r + ADDR_W'(i_r);

  // Address and valid are pure functions of registered state, so they stay
  // stable for the whole ADDR stall and read zero everywhere else.
  assign arg_0_s_axil_arvalid = (state == ST_ADDR);
  assign arg_0_s_axil_araddr  = (state == ST_ADDR) ? (word_idx << SHIFT) : '0;
  assign arg_0_s_axil_arprot  = 3'b000;

  // Only take a beat when the holding register can absorb it.
  assign arg_0_s_axil_rready = (state == ST_DATA) && reg_in_ready;
  assign beat_fire           = arg_0_s_axil_rvalid && arg_0_s_axil_rready;
  assign beat_err            = (arg_0_s_axil_rresp != RESP_OKAY);

`ifdef AXI_RD_ERR_ABORT_EN
  assign reg_in_valid = beat_fire && !beat_err;
`else
  assign reg_in_valid = beat_fire;
`endif

  axi_rd_outreg #(
    .DATA_W(DATA_W)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .in_data  (arg_0_s_axil_rdata),
    .in_valid (reg_in_valid),
    .in_ready (reg_in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Burst sequencer: one address phase, then one data phase, per word.
  // done is registered so it pulses in the first IDLE cycle after FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      base_r  <= '0;
      count_r <= '0;
      i_r     <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_r  <= base_idx;
            count_r <= count;
            i_r     <= '0;
            err     <= 1'b0;
            state   <= (count == '0) ? ST_FIN : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arg_0_s_axil_arready) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            i_r <= i_next;
            if (beat_err) begin
              err <= 1'b1;
            end
`ifdef AXI_RD_ERR_ABORT_EN
            if (beat_err) begin
              state <= ST_FIN;
            end else if (i_next < count_r) begin
              state <= ST_ADDR;
            end else begin
              state <= ST_FIN;
            end
`else
            if (i_next < count_r) begin
              state <= ST_ADDR;
            end else begin
              state <= ST_FIN;
            end
`endif
          end
        end
        ST_FIN: begin
          // Hold completion until the last word has left the register.
          if (!out_valid) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
